// File: rtl/dmem_vga_arbiter_if.sv
// Bus bundle between the CPU load/store port, the VGA pixel-fetch port and a
// single-port synchronous-read data memory.
interface dmem_vga_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_valid;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  vga_req, vga_addr,
    output vga_gnt, vga_rdata, vga_valid,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester / memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output vga_req, vga_addr,
    input  vga_gnt, vga_rdata, vga_valid,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_vga_arbiter.sv
// Shares one single-port dmem between the CPU and the VGA fetcher. VGA has
// fixed priority; a wait counter lets a starved CPU win one grant.
module dmem_vga_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  dmem_vga_arbiter_if.slave   bus
);

  localparam logic [3:0]        WAIT_LIMIT = 4'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = '0;
  localparam logic [DATA_W-1:0] DATA_ZERO  = '0;

  logic              cpu_pending;
  logic              vga_pending;
  logic [3:0]        wait_cnt;
  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] vga_hold;

  logic cpu_elig;
  logic cpu_grant;
  logic vga_grant;

  // A held CPU request is ineligible while its response is in flight.
  always_comb begin
    cpu_elig  = bus.cpu_req & ~cpu_pending;
    cpu_grant = 1'b0;
    vga_grant = 1'b0;
    if (reset) begin
      if (cpu_elig && (!bus.vga_req || wait_cnt == WAIT_LIMIT)) begin
        cpu_grant = 1'b1;
      end else if (bus.vga_req) begin
        vga_grant = 1'b1;
      end
    end
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = ADDR_ZERO;
    bus.mem_wdata = DATA_ZERO;
    if (cpu_grant) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (vga_grant) begin
      bus.mem_addr  = bus.vga_addr;
    end
  end

  assign bus.vga_gnt   = vga_grant;
  assign bus.cpu_ready = cpu_pending;
  assign bus.vga_valid = vga_pending;

  // Read data passes straight through in the response cycle, then is held.
  assign bus.cpu_rdata = cpu_pending ? bus.mem_rdata : cpu_hold;
  assign bus.vga_rdata = vga_pending ? bus.mem_rdata : vga_hold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_pending <= 1'b0;
      vga_pending <= 1'b0;
      wait_cnt    <= 4'd0;
      cpu_hold    <= DATA_ZERO;
      vga_hold    <= DATA_ZERO;
    end else begin
      cpu_pending <= cpu_grant;
      vga_pending <= vga_grant;

      if (cpu_pending) begin
        cpu_hold <= bus.mem_rdata;
      end
      if (vga_pending) begin
        vga_hold <= bus.mem_rdata;
      end

      if (cpu_grant || !bus.cpu_req) begin
        wait_cnt <= 4'd0;
      end else if (cpu_elig && wait_cnt != WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_vga_arbiter.sv
// Directed bench for dmem_vga_arbiter with a word-addressed synchronous-read
// memory model hanging off the mem_* side of the bus.
module tb_dmem_vga_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem_init = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dmem_vga_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_vga_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Word i preloads to 0xA5A5_0000+i, except byte address 0x10 (word 4).
  logic [31:0] mem [0:255];
  always_ff @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] <= (i == 4) ? 32'hDEADBEEF : 32'hA5A5_0000 + 32'(i);
      end
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr[9:2]];
  end

  task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic vreq, input logic [31:0] vaddr);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.vga_req   = vreq;
    bus.vga_addr  = vaddr;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h20, 32'hBAD0BAD0, 1'b1, 32'h40);
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
    n_checks++; if (bus.vga_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_vga_gnt: got %b expected 0", bus.vga_gnt); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
    next_cycle();
    applyStimulus(1'b1, 1'b1, 32'h20, 32'hBAD0BAD0, 1'b1, 32'h40);
    n_checks++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cpu_ready: got %b expected 0", bus.cpu_ready); end
    n_checks++; if (bus.vga_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_vga_valid: got %b expected 0", bus.vga_valid); end
    n_checks++; if (bus.cpu_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_cpu_rdata: got %h expected 0", bus.cpu_rdata); end
    n_checks++; if (bus.vga_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_vga_rdata: got %h expected 0", bus.vga_rdata); end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_cpu_read();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    n_checks++; if (bus.mem_addr !== 32'h10) begin n_fail++; $display("[TB] FAIL rd_mem_addr: got %h expected 10", bus.mem_addr); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_mem_we: got %b expected 0", bus.mem_we); end
    n_checks++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_early_ready: got %b expected 0", bus.cpu_ready); end
    next_cycle();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    n_checks++; if (bus.cpu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_ready: got %b expected 1", bus.cpu_ready); end
    n_checks++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL rd_data: got %h expected deadbeef", bus.cpu_rdata); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL rd_no_regrant: mem_addr got %h expected 0", bus.mem_addr); end
    next_cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    n_checks++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_ready_pulse: got %b expected 0", bus.cpu_ready); end
    n_checks++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL rd_hold: got %h expected deadbeef", bus.cpu_rdata); end
    next_cycle();
  endtask

  task automatic test_cpu_write();
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0);
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_mem_we: got %b expected 1", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 32'h20) begin n_fail++; $display("[TB] FAIL wr_mem_addr: got %h expected 20", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h12345678) begin n_fail++; $display("[TB] FAIL wr_mem_wdata: got %h expected 12345678", bus.mem_wdata); end
    next_cycle();
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
    n_checks++; if (bus.cpu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_ready: got %b expected 1", bus.cpu_ready); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_we_once: got %b expected 0", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL wr_next_not_elig: mem_addr got %h expected 0", bus.mem_addr); end
    next_cycle();
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
    n_checks++; if (bus.mem_addr !== 32'h20) begin n_fail++; $display("[TB] FAIL wr_readback_addr: got %h expected 20", bus.mem_addr); end
    n_checks++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_readback_early: got %b expected 0", bus.cpu_ready); end
    next_cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    n_checks++; if (bus.cpu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_readback_ready: got %b expected 1", bus.cpu_ready); end
    n_checks++; if (bus.cpu_rdata !== 32'h12345678) begin n_fail++; $display("[TB] FAIL wr_readback_data: got %h expected 12345678", bus.cpu_rdata); end
    next_cycle();
  endtask

  task automatic test_starvation();
    for (int c = 0; c <= 5; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'h40);
      if (c <= 3) begin
        n_checks++; if (bus.vga_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL starve_vga_gnt c%0d: got %b expected 1", c, bus.vga_gnt); end
        n_checks++; if (bus.mem_addr !== 32'h40) begin n_fail++; $display("[TB] FAIL starve_mem_addr c%0d: got %h expected 40", c, bus.mem_addr); end
      end
      if (c >= 1 && c <= 4) begin
        n_checks++; if (bus.vga_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL starve_vga_valid c%0d: got %b expected 1", c, bus.vga_valid); end
        n_checks++; if (bus.vga_rdata !== 32'hA5A50010) begin n_fail++; $display("[TB] FAIL starve_vga_rdata c%0d: got %h expected a5a50010", c, bus.vga_rdata); end
      end
      if (c == 4) begin
        n_checks++; if (bus.vga_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL starve_cpu_win_gnt: got %b expected 0", bus.vga_gnt); end
        n_checks++; if (bus.mem_addr !== 32'h10) begin n_fail++; $display("[TB] FAIL starve_cpu_win_addr: got %h expected 10", bus.mem_addr); end
      end
      if (c == 5) begin
        n_checks++; if (bus.cpu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL starve_ready: got %b expected 1", bus.cpu_ready); end
        n_checks++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL starve_cpu_rdata: got %h expected deadbeef", bus.cpu_rdata); end
        n_checks++; if (bus.vga_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL starve_vga_regain: got %b expected 1", bus.vga_gnt); end
        n_checks++; if (bus.vga_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL starve_vga_gap: got %b expected 0", bus.vga_valid); end
      end
      next_cycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    next_cycle();
  endtask

  task automatic test_cancel();
    for (int c = 0; c <= 9; c++) begin
      applyStimulus((c != 3) ? 1'b1 : 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 32'h44);
      if (c <= 7) begin
        n_checks++; if (bus.vga_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL cancel_vga_gnt c%0d: got %b expected 1", c, bus.vga_gnt); end
      end
      if (c == 3) begin
        n_checks++; if (bus.mem_addr !== 32'h44) begin n_fail++; $display("[TB] FAIL cancel_no_access: mem_addr got %h expected 44", bus.mem_addr); end
      end
      if (c == 8) begin
        n_checks++; if (bus.mem_addr !== 32'h10) begin n_fail++; $display("[TB] FAIL cancel_cpu_grant: mem_addr got %h expected 10", bus.mem_addr); end
      end
      if (c == 9) begin
        n_checks++; if (bus.cpu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL cancel_ready: got %b expected 1", bus.cpu_ready); end
      end
      next_cycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    next_cycle();
  endtask

  task automatic test_simultaneous();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'h44);
    n_checks++; if (bus.vga_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL simul_vga_gnt: got %b expected 1", bus.vga_gnt); end
    n_checks++; if (bus.mem_addr !== 32'h44) begin n_fail++; $display("[TB] FAIL simul_mem_addr: got %h expected 44", bus.mem_addr); end
    next_cycle();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    n_checks++; if (bus.vga_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL simul_vga_valid: got %b expected 1", bus.vga_valid); end
    n_checks++; if (bus.vga_rdata !== 32'hA5A50011) begin n_fail++; $display("[TB] FAIL simul_vga_rdata: got %h expected a5a50011", bus.vga_rdata); end
    n_checks++; if (bus.mem_addr !== 32'h10) begin n_fail++; $display("[TB] FAIL simul_cpu_next: mem_addr got %h expected 10", bus.mem_addr); end
    next_cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    n_checks++; if (bus.cpu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL simul_cpu_ready: got %b expected 1", bus.cpu_ready); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    n_checks++; if (bus.mem_addr !== 32'h10) begin n_fail++; $display("[TB] FAIL rstmid_grant: mem_addr got %h expected 10", bus.mem_addr); end
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h20, 32'hBAD0BAD0, 1'b1, 32'h40);
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_we_pre: got %b expected 0", bus.mem_we); end
    next_cycle();
    applyStimulus(1'b1, 1'b1, 32'h20, 32'hBAD0BAD0, 1'b1, 32'h40);
    n_checks++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_cpu_ready: got %b expected 0", bus.cpu_ready); end
    n_checks++; if (bus.vga_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_vga_valid: got %b expected 0", bus.vga_valid); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_mem_we: got %b expected 0", bus.mem_we); end
    n_checks++; if (bus.cpu_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rstmid_cpu_rdata: got %h expected 0", bus.cpu_rdata); end
    n_checks++; if (bus.vga_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rstmid_vga_rdata: got %h expected 0", bus.vga_rdata); end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;
    next_cycle();
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    n_checks++; if (bus.cpu_rdata !== 32'h12345678) begin n_fail++; $display("[TB] FAIL rstmid_mem_intact: got %h expected 12345678", bus.cpu_rdata); end
    next_cycle();
  endtask

  task automatic test_idle();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    n_checks++; if (bus.vga_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_setup_valid: got %b expected 1", bus.vga_valid); end
    next_cycle();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_mem_we c%0d: got %b expected 0", c, bus.mem_we); end
      n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL idle_mem_addr c%0d: got %h expected 0", c, bus.mem_addr); end
      n_checks++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL idle_cpu_hold c%0d: got %h expected deadbeef", c, bus.cpu_rdata); end
      n_checks++; if (bus.vga_rdata !== 32'hA5A50010) begin n_fail++; $display("[TB] FAIL idle_vga_hold c%0d: got %h expected a5a50010", c, bus.vga_rdata); end
      n_checks++; if (bus.vga_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_vga_valid c%0d: got %b expected 0", c, bus.vga_valid); end
      next_cycle();
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
    mem_init = 1'b0;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_starvation();
    test_cancel();
    test_simultaneous();
    test_reset_mid();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
